lane_dropper: RTL and testbench
===============================

Name: lane_dropper

Overview:
- Parametrised per-lane note dropper for the rhythm game; generalises the fixed single-arrow droppers.
- Drops a sequence of NUM_NOTES arrows down one lane, one at a time, with a configurable start delay, inter-note gap and fall speed.
- Grades each note as hit or miss and keeps per-lane hit/miss counts.
- Feeds position and visibility to the sprite/colour mapper, and hit/miss pulses to the score block.

Parameters:
LANE_X, 500, fixed X position of the lane (10-bit)
KEY_CODE, 8'h4f, USB keycode that hits this lane
START_KEY, 8'h2c, keycode that starts the sequence
RESTART_KEY, 8'h01, keycode that returns from DONE to IDLE
Y_START, 100, spawn Y of each arrow (top edge)
Y_MAX, 400, bottom limit; arrow bottom reaching it is a miss
ARROW_H, 40, arrow height in pixels
HIT_LO, 340, lowest bottom-edge Y (inclusive) of the hit window
START_DELAY, 220, frames from start to the first note
NOTE_GAP, 60, frames between one note's result and the next spawn
NUM_NOTES, 4, notes in the sequence (1..255)
SPEED, 1, pixels moved per frame (1..8)

Ports:
frame_clk  in  1  frame clock; the only clock
Reset  in  1  synchronous, active-high reset
keycode  in  8  first keyboard slot
keycode_second  in  8  second keyboard slot
dropX  out  10  arrow X position (always LANE_X)
dropY  out  10  arrow top Y
visible  out  1  arrow is on screen
hit_pulse  out  1  one-frame pulse when a note is hit
miss_pulse  out  1  one-frame pulse when a note is missed
hit_count  out  8  hits since last start
miss_count  out  8  misses since last start
done  out  1  sequence finished
perfect_pulse  out  1  perfect-grade pulse (see Optional Feature)

Behaviour:
- One clock, frame_clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; dropY = Y_START; visible, both pulses, done and perfect_pulse = 0; both counts = 0; frame counter = 0; note index = 0.
- Reset asserted mid-operation aborts the sequence and restores the reset values on the next edge.
- Key decode:
  - match = (keycode == KEY_CODE) || (keycode_second == KEY_CODE).
  - press = match && !match_q, where match_q is match registered one frame earlier (rising edge). A held key yields exactly one press.
  - START_KEY and RESTART_KEY are level-checked in either slot.
- IDLE: when START_KEY is seen → WAIT. On that transition: frame counter = 0, note index = 0, counts cleared.
- WAIT:
  - Counter increments every frame.
  - When counter == delay-1 → FALL, with dropY = Y_START, visible = 1, counter = 0.
  - delay is START_DELAY for note 0 and NOTE_GAP for later notes.
- FALL: each frame, with bottom = dropY + ARROW_H, evaluate in this priority order:
  1. If bottom >= Y_MAX: miss. miss_pulse = 1, miss_count + 1, visible = 0.
  2. Else if press and HIT_LO <= bottom < Y_MAX: hit. hit_pulse = 1, hit_count + 1, visible = 0.
  3. Else dropY = dropY + SPEED. Use 11-bit arithmetic internally and clamp so dropY never exceeds Y_MAX - ARROW_H.
- A press outside the hit window is ignored: no penalty, no effect.
- After a hit or miss:
  - If note index == NUM_NOTES-1 → DONE.
  - Otherwise note index + 1 → WAIT, counter = 0.
- Pulses last exactly one frame. Counts saturate at 255.
- DONE: done = 1, visible = 0. When RESTART_KEY is seen → IDLE; done clears and the counts are held until the next start.
- A press and a bottom >= Y_MAX in the same frame resolve as a miss.
- START_KEY is ignored outside IDLE. RESTART_KEY is ignored outside DONE.

Optional Feature:
PERFECT_GRADE_EN
- Defined: a hit whose bottom lies in [HIT_LO+20, HIT_LO+40) also asserts perfect_pulse for the same frame.
- Defined: an 8-bit internal perfect counter is added, readable through the package debug hook.
- Undefined: perfect_pulse is tied to 0 and no counter logic exists.

Decomposition:
- Package rhythm_pkg holds:
  - keycode constants: KEY_SPACE 8'h2c, KEY_ESC 8'h01, KEY_RIGHT 8'h4f, KEY_LEFT 8'h50, KEY_DOWN 8'h51, KEY_UP 8'h52;
  - the lane_state_t enum (IDLE, WAIT, FALL, DONE);
  - the shared Y_START, Y_MAX and ARROW_H defaults;
  - the 40x40 arrow bitmaps as 1600-bit constants, consumed by the colour mapper rather than this block.
- Sub-module key_edge_detect: dual-slot keycode compare plus rising-edge register; one instance per lane.

Test Plan:
- Defaults; Reset high for 2 frames → dropY = 100, visible = 0, counts = 0, done = 0.
- START_KEY for 1 frame, no hit key → visible rises at frame 220; miss_pulse fires when dropY reaches 360, after 260 fall frames; repeats for 4 notes; then done = 1 and miss_count = 4.
- Hit key pressed 1 frame when dropY = 300 (bottom 340) → hit_pulse on that frame, hit_count = 1, visible = 0; next spawn 60 frames later.
- Hit key held from dropY = 250 onward → no hit; the note misses, because there is no rising edge inside the window.
- Reset asserted while dropY = 200 in FALL → IDLE next frame; dropY = 100, counts = 0; a later START_KEY restarts from note 0.
- Press on the frame bottom = 400 → miss_pulse only; with PERFECT_GRADE_EN, a press at bottom 365 → hit_pulse and perfect_pulse together.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared rhythm-game definitions: keycodes, lane FSM states, playfield defaults and arrow bitmaps.
// The lane debug struct carries the perfect counter when PERFECT_GRADE_EN is defined.
package rhythm_pkg;

    localparam logic [7:0] KEY_SPACE = 8'h2c;
    localparam logic [7:0] KEY_ESC   = 8'h01;
    localparam logic [7:0] KEY_RIGHT = 8'h4f;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    typedef enum logic [1:0] {IDLE, WAIT, FALL, DONE} lane_state_t;

    localparam int DEF_Y_START = 100;
    localparam int DEF_Y_MAX   = 400;
    localparam int DEF_ARROW_H = 40;

    typedef struct packed {
        lane_state_t state;
        logic [7:0]  note;
        logic [7:0]  perfect_count;
    } lane_dbg_t;

    // Solid triangle arrow; bit r*40+c is row r, column c. dir: 0 up, 1 down, 2 left, 3 right.
    function automatic logic [1599:0] arrow_bitmap(input logic [1:0] dir);
        logic [1599:0] bm;
        int rr, cc, d;
        bm = '0;
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < 40; c++) begin
                case (dir)
                    2'd0:    begin rr = r;      cc = c; end
                    2'd1:    begin rr = 39 - r; cc = c; end
                    2'd2:    begin rr = c;      cc = r; end
                    default: begin rr = 39 - c; cc = r; end
                endcase
                d = (cc >= 20) ? cc - 20 : 20 - cc;
                if (2 * d <= rr) bm[r*40+c] = 1'b1;
            end
        end
        return bm;
    endfunction

    localparam logic [1599:0] ARROW_UP_BMP    = arrow_bitmap(2'd0);
    localparam logic [1599:0] ARROW_DOWN_BMP  = arrow_bitmap(2'd1);
    localparam logic [1599:0] ARROW_LEFT_BMP  = arrow_bitmap(2'd2);
    localparam logic [1599:0] ARROW_RIGHT_BMP = arrow_bitmap(2'd3);

endpackage

// File: rtl/key_edge_detect.sv
// Dual-slot keycode match with a one-frame delayed copy, giving a single press per key-down.
module key_edge_detect #(
    parameter logic [7:0] KEY_CODE = 8'h4f
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] keycode_i,
    input  logic [7:0] keycode_second_i,
    output logic       match_o,
    output logic       press_o
);
    logic match_q;

    assign match_o = (keycode_i == KEY_CODE) || (keycode_second_i == KEY_CODE);
    assign press_o = match_o && !match_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) match_q <= 1'b0;
        else       match_q <= match_o;
    end
endmodule

// File: rtl/lane_dropper.sv
// One rhythm-game lane: drops NUM_NOTES arrows, grades hit/miss, keeps saturating counts.
// Optional macro PERFECT_GRADE_EN adds perfect_pulse and an internal perfect counter.
module lane_dropper
    import rhythm_pkg::*;
#(
    parameter logic [9:0] LANE_X      = 10'd500,
    parameter logic [7:0] KEY_CODE    = 8'h4f,
    parameter logic [7:0] START_KEY   = 8'h2c,
    parameter logic [7:0] RESTART_KEY = 8'h01,
    parameter int         Y_START     = DEF_Y_START,
    parameter int         Y_MAX       = DEF_Y_MAX,
    parameter int         ARROW_H     = DEF_ARROW_H,
    parameter int         HIT_LO      = 340,
    parameter int         START_DELAY = 220,
    parameter int         NOTE_GAP    = 60,
    parameter int         NUM_NOTES   = 4,
    parameter int         SPEED       = 1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode_second,
    output logic [9:0] dropX,
    output logic [9:0] dropY,
    output logic       visible,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic       done,
    output logic       perfect_pulse
);
    localparam logic [9:0]  Y_START10  = 10'(Y_START);
    localparam logic [10:0] Y_MAX11    = 11'(Y_MAX);
    localparam logic [10:0] ARROW_H11  = 11'(ARROW_H);
    localparam logic [10:0] HIT_LO11   = 11'(HIT_LO);
    localparam logic [10:0] SPEED11    = 11'(SPEED);
    localparam logic [10:0] Y_CLAMP11  = 11'(Y_MAX - ARROW_H);
    localparam logic [15:0] FIRST_DLY  = 16'(START_DELAY - 1);
    localparam logic [15:0] GAP_DLY    = 16'(NOTE_GAP - 1);
    localparam logic [7:0]  LAST_NOTE  = 8'(NUM_NOTES - 1);

    lane_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  note_q, note_d;
    logic [9:0]  y_q, y_d;
    logic        vis_q, vis_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic [7:0]  hits_q, hits_d;
    logic [7:0]  misses_q, misses_d;
    logic        done_q, done_d;

    logic        key_match, key_press;
    logic        start_seen, restart_seen;
    logic [10:0] bottom, y_next;
    logic        hit_now;

    key_edge_detect #(.KEY_CODE(KEY_CODE)) u_key (
        .clk_i            (frame_clk),
        .rst_i            (Reset),
        .keycode_i        (keycode),
        .keycode_second_i (keycode_second),
        .match_o          (key_match),
        .press_o          (key_press)
    );

    assign start_seen   = (keycode == START_KEY)   || (keycode_second == START_KEY);
    assign restart_seen = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);

    assign bottom  = {1'b0, y_q} + ARROW_H11;
    assign hit_now = (state_q == FALL) && (bottom < Y_MAX11) && key_press && (bottom >= HIT_LO11);

    always_comb begin
        y_next = {1'b0, y_q} + SPEED11;
        if (y_next > Y_CLAMP11) y_next = Y_CLAMP11;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        note_d   = note_q;
        y_d      = y_q;
        vis_d    = vis_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        hits_d   = hits_q;
        misses_d = misses_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start_seen) begin
                    state_d  = WAIT;
                    cnt_d    = '0;
                    note_d   = '0;
                    hits_d   = '0;
                    misses_d = '0;
                end
            end
            WAIT: begin
                if (cnt_q == ((note_q == 8'd0) ? FIRST_DLY : GAP_DLY)) begin
                    state_d = FALL;
                    y_d     = Y_START10;
                    vis_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FALL: begin
                if (bottom >= Y_MAX11 || hit_now) begin
                    // Miss has priority over a press landing on the same frame.
                    if (bottom >= Y_MAX11) begin
                        miss_d   = 1'b1;
                        misses_d = (misses_q == 8'hff) ? misses_q : misses_q + 8'd1;
                    end else begin
                        hit_d  = 1'b1;
                        hits_d = (hits_q == 8'hff) ? hits_q : hits_q + 8'd1;
                    end
                    vis_d = 1'b0;
                    if (note_q == LAST_NOTE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        note_d  = note_q + 8'd1;
                        cnt_d   = '0;
                    end
                end else begin
                    y_d = y_next[9:0];
                end
            end
            DONE: begin
                done_d = 1'b1;
                vis_d  = 1'b0;
                if (restart_seen) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            note_q   <= '0;
            y_q      <= Y_START10;
            vis_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            note_q   <= note_d;
            y_q      <= y_d;
            vis_q    <= vis_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            done_q   <= done_d;
        end
    end

`ifdef PERFECT_GRADE_EN
    logic       perf_q, perf_d;
    logic [7:0] perf_cnt_q, perf_cnt_d;
    lane_dbg_t  dbg;

    always_comb begin
        perf_d     = hit_now && (bottom >= HIT_LO11 + 11'd20) && (bottom < HIT_LO11 + 11'd40);
        perf_cnt_d = perf_cnt_q;
        if (state_q == IDLE && start_seen)          perf_cnt_d = '0;
        else if (perf_d && perf_cnt_q != 8'hff)     perf_cnt_d = perf_cnt_q + 8'd1;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            perf_q     <= 1'b0;
            perf_cnt_q <= '0;
        end else begin
            perf_q     <= perf_d;
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign dbg           = '{state: state_q, note: note_q, perfect_count: perf_cnt_q};
    assign perfect_pulse = perf_q;
`else
    assign perfect_pulse = 1'b0;
`endif

    assign dropX      = LANE_X;
    assign dropY      = y_q;
    assign visible    = vis_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign hit_count  = hits_q;
    assign miss_count = misses_q;
    assign done       = done_q;

    logic unused_ok;
    assign unused_ok = key_match;
endmodule

// File: tb/tb_lane_dropper.sv
// Directed bench for lane_dropper with default parameters; expectations are hand-derived frame counts.
module tb_lane_dropper;
    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode, keycode_second;
    logic [9:0] dropX, dropY;
    logic       visible, hit_pulse, miss_pulse, done, perfect_pulse;
    logic [7:0] hit_count, miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

`ifdef PERFECT_GRADE_EN
    localparam logic EXP_PERF = 1'b1;
`else
    localparam logic EXP_PERF = 1'b0;
`endif

    lane_dropper dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .dropX          (dropX),
        .dropY          (dropY),
        .visible        (visible),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .done           (done),
        .perfect_pulse  (perfect_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Frames until the selected output goes high: 0 visible, 1 miss_pulse, 2 hit_pulse. -1 on timeout.
    task automatic count_until(input int which, output int frames);
        logic hit;
        frames = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge frame_clk);
            case (which)
                0:       hit = visible;
                1:       hit = miss_pulse;
                default: hit = hit_pulse;
            endcase
            if (hit) begin
                frames = i;
                break;
            end
        end
    endtask

    task automatic wait_y(input string tag, input logic [9:0] y);
        int k = 0;
        while (dropY != y && k < 1000) begin
            @(negedge frame_clk);
            k++;
        end
        check(tag, dropY, y);
    endtask

    task automatic press_start();
        keycode = 8'h2c;
        @(negedge frame_clk);
        keycode = 8'h00;
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        keycode_second = 8'h00;
        repeat (2) @(negedge frame_clk);
        check("rst_dropY", dropY, 100);
        check("rst_dropX", dropX, 500);
        check("rst_visible", visible, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        check("rst_done", done, 0);
        check("rst_pulses", {hit_pulse, miss_pulse, perfect_pulse}, 0);
        Reset = 1'b0;

        // A lane key pressed in IDLE has no effect.
        keycode = 8'h4f;
        repeat (3) @(negedge frame_clk);
        keycode = 8'h00;
        check("idle_key_ignored", {visible, hit_count, miss_count}, 0);

        // Full unplayed sequence: four misses.
        press_start();
        count_until(0, n);
        check("first_spawn_frames", n, 220);
        check("spawn_dropY", dropY, 100);
        count_until(1, n);
        check("first_miss_frames", n, 261);
        check("miss_dropY", dropY, 360);
        check("miss_visible", visible, 0);
        check("miss_count1", miss_count, 1);
        for (int i = 1; i < 4; i++) begin
            count_until(0, n);
            check("gap_frames", n, 60);
            count_until(1, n);
            check("fall_frames", n, 261);
        end
        check("done_set", done, 1);
        check("miss_count4", miss_count, 4);
        @(negedge frame_clk);
        check("miss_pulse_one_frame", miss_pulse, 0);

        // Start is ignored in DONE; restart returns to IDLE holding counts.
        press_start();
        check("start_ignored_done", done, 1);
        keycode = 8'h01;
        @(negedge frame_clk);
        keycode = 8'h00;
        check("restart_done_clear", done, 0);
        check("restart_counts_held", miss_count, 4);

        press_start();
        check("start_clears_misses", miss_count, 0);
        count_until(0, n);
        check("spawn2_frames", n, 220);

        // Hit at the lower edge of the window (bottom 340).
        wait_y("reach_300", 10'd300);
        keycode = 8'h4f;
        @(negedge frame_clk);
        check("hit_pulse", hit_pulse, 1);
        check("hit_no_miss", miss_pulse, 0);
        check("hit_count1", hit_count, 1);
        check("hit_visible", visible, 0);
        check("hit_no_perfect", perfect_pulse, 0);
        keycode = 8'h00;
        count_until(0, n);
        check("gap_after_hit", n, 60);

        // Key held from dropY 250: no rising edge in window, so it misses.
        wait_y("reach_250", 10'd250);
        keycode = 8'h4f;
        count_until(1, n);
        check("held_miss_frames", n, 111);
        check("held_no_hit", hit_count, 1);
        check("held_miss_count", miss_count, 1);
        keycode = 8'h00;

        // Reset mid-fall aborts everything.
        count_until(0, n);
        check("gap_before_reset", n, 60);
        wait_y("reach_200", 10'd200);
        Reset = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
        check("abort_dropY", dropY, 100);
        check("abort_visible", visible, 0);
        check("abort_counts", {hit_count, miss_count}, 0);
        repeat (5) @(negedge frame_clk);
        check("abort_stays_idle", visible, 0);
        press_start();
        count_until(0, n);
        check("restart_note0_delay", n, 220);

        // Press on the frame the bottom reaches Y_MAX: miss wins.
        wait_y("reach_360", 10'd360);
        keycode = 8'h4f;
        @(negedge frame_clk);
        check("edge_press_miss", miss_pulse, 1);
        check("edge_press_no_hit", hit_pulse, 0);
        keycode = 8'h00;

        // Press just above the window is ignored; a later second-slot press hits at bottom 370.
        count_until(0, n);
        check("gap_edge", n, 60);
        wait_y("reach_299", 10'd299);
        keycode = 8'h4f;
        @(negedge frame_clk);
        check("early_press_ignored", hit_pulse, 0);
        check("early_press_moves", dropY, 300);
        keycode = 8'h00;
        wait_y("reach_330", 10'd330);
        keycode_second = 8'h4f;
        @(negedge frame_clk);
        check("slot2_hit", hit_pulse, 1);
        check("slot2_perfect", perfect_pulse, EXP_PERF);
        check("slot2_hit_count", hit_count, 1);
        keycode_second = 8'h00;
        @(negedge frame_clk);
        check("hit_pulse_one_frame", {hit_pulse, perfect_pulse}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
